// File: rtl/x_corr_src_pkg.sv
// Shared definitions for the cross-correlator sample source: FSM encoding,
// buffer select values and a small width helper.
package x_corr_src_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   localparam logic SEL_X = 1'b0;
   localparam logic SEL_Y = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/x_corr_src_buf.sv
// Length-deep complex sample register file: one write port, one
// combinational read port. Contents are intentionally not reset.
module x_corr_src_buf #(
   parameter int depth  = 5,
   parameter int aw     = 3,
   parameter int i_bits = 12,
   parameter int q_bits = 12
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [aw-1:0]     i_wr_addr,
   input  logic [i_bits-1:0] i_wr_i,
   input  logic [q_bits-1:0] i_wr_q,
   input  logic [aw-1:0]     i_rd_addr,
   output logic [i_bits-1:0] o_rd_i,
   output logic [q_bits-1:0] o_rd_q
);

   logic [i_bits-1:0] r_mem_i [depth];
   logic [q_bits-1:0] r_mem_q [depth];

   always_ff @(posedge clk) begin
      if (i_wr_en && (i_wr_addr < aw'(depth))) begin
         r_mem_i[i_wr_addr] <= i_wr_i;
         r_mem_q[i_wr_addr] <= i_wr_q;
      end
   end

   assign o_rd_i = (i_rd_addr < aw'(depth)) ? r_mem_i[i_rd_addr] : '0;
   assign o_rd_q = (i_rd_addr < aw'(depth)) ? r_mem_q[i_rd_addr] : '0;

endmodule

// File: rtl/x_corr_src.sv
// Streams every circular lag of the received block y against the reference
// block x into the correlator, one registered sample per handshake.
//
// state     | meaning
// ST_IDLE   | buffers writable, waiting for start
// ST_STREAM | sweeping (k,s); output register holds the current sample
module x_corr_src
   import x_corr_src_pkg::*;
#(
   parameter int xi_bits             = 12,
   parameter int xq_bits             = 12,
   parameter int yi_bits             = 12,
   parameter int yq_bits             = 12,
   parameter int length              = 5,
   parameter int length_counter_bits = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_en,
   input  logic                                  wr_sel,
   input  logic [length_counter_bits-1:0]        wr_addr,
   input  logic [max_int(xi_bits, yi_bits)-1:0]  wr_i,
   input  logic [max_int(xq_bits, yq_bits)-1:0]  wr_q,
   input  logic                                  start,
   output logic [xi_bits-1:0]                    xi,
   output logic [xq_bits-1:0]                    xq,
   output logic [yi_bits-1:0]                    yi,
   output logic [yq_bits-1:0]                    yq,
   output logic                                  m_axis_tvalid,
   input  logic                                  s_axis_tready,
   output logic                                  sample_last,
   output logic [length_counter_bits-1:0]        shift,
   output logic                                  busy,
   output logic                                  done
);

   localparam int              CB     = length_counter_bits;
   localparam logic [CB-1:0]   K_LAST = CB'(length - 1);
   localparam logic [CB:0]     LEN_W  = (CB + 1)'(length);

   state_t              r_state;
   logic [CB-1:0]       r_k, r_s;
   logic [xi_bits-1:0]  r_xi;
   logic [xq_bits-1:0]  r_xq;
   logic [yi_bits-1:0]  r_yi;
   logic [yq_bits-1:0]  r_yq;
   logic                r_valid, r_last, r_done;

   logic                w_idle, w_hs, w_is_last;
   logic                w_wr_ok, w_wr_x, w_wr_y;
   logic [CB-1:0]       w_k_nxt, w_s_nxt, w_y_addr;
   logic [CB:0]         w_sum;
   logic [xi_bits-1:0]  w_xbuf_i, w_x_i;
   logic [xq_bits-1:0]  w_xbuf_q, w_x_q;
   logic [yi_bits-1:0]  w_ybuf_i, w_y_i;
   logic [yq_bits-1:0]  w_ybuf_q, w_y_q;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_hs      = r_valid & s_axis_tready;
   assign w_is_last = (r_k == K_LAST) && (r_s == K_LAST);

   assign w_wr_ok = wr_en && w_idle && (wr_addr < CB'(length));
   assign w_wr_x  = w_wr_ok && (wr_sel == SEL_X);
   assign w_wr_y  = w_wr_ok && (wr_sel == SEL_Y);

   // Address of the sample the output register will load next; (0,0) from IDLE.
   always_comb begin
      w_k_nxt = '0;
      w_s_nxt = '0;
      if (!w_idle) begin
         if (r_k == K_LAST) begin
            w_s_nxt = r_s + 1'b1;
         end else begin
            w_k_nxt = r_k + 1'b1;
            w_s_nxt = r_s;
         end
      end
   end

   assign w_sum    = {1'b0, w_k_nxt} + {1'b0, w_s_nxt};
   assign w_y_addr = (w_sum >= LEN_W) ? CB'(w_sum - LEN_W) : CB'(w_sum);

   x_corr_src_buf #(
      .depth(length), .aw(CB), .i_bits(xi_bits), .q_bits(xq_bits)
   ) u_buf_x (
      .clk      (clk),
      .i_wr_en  (w_wr_x),
      .i_wr_addr(wr_addr),
      .i_wr_i   (wr_i[xi_bits-1:0]),
      .i_wr_q   (wr_q[xq_bits-1:0]),
      .i_rd_addr(w_k_nxt),
      .o_rd_i   (w_xbuf_i),
      .o_rd_q   (w_xbuf_q)
   );

   x_corr_src_buf #(
      .depth(length), .aw(CB), .i_bits(yi_bits), .q_bits(yq_bits)
   ) u_buf_y (
      .clk      (clk),
      .i_wr_en  (w_wr_y),
      .i_wr_addr(wr_addr),
      .i_wr_i   (wr_i[yi_bits-1:0]),
      .i_wr_q   (wr_q[yq_bits-1:0]),
      .i_rd_addr(w_y_addr),
      .o_rd_i   (w_ybuf_i),
      .o_rd_q   (w_ybuf_q)
   );

   // Forward a write landing on the same edge as start so the first sample sees it.
   assign w_x_i = (w_wr_x && (wr_addr == w_k_nxt))  ? wr_i[xi_bits-1:0] : w_xbuf_i;
   assign w_x_q = (w_wr_x && (wr_addr == w_k_nxt))  ? wr_q[xq_bits-1:0] : w_xbuf_q;
   assign w_y_i = (w_wr_y && (wr_addr == w_y_addr)) ? wr_i[yi_bits-1:0] : w_ybuf_i;
   assign w_y_q = (w_wr_y && (wr_addr == w_y_addr)) ? wr_q[yq_bits-1:0] : w_ybuf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_s     <= '0;
         r_xi    <= '0;
         r_xq    <= '0;
         r_yi    <= '0;
         r_yq    <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_STREAM;
                  r_k     <= '0;
                  r_s     <= '0;
                  r_xi    <= w_x_i;
                  r_xq    <= w_x_q;
                  r_yi    <= w_y_i;
                  r_yq    <= w_y_q;
                  r_valid <= 1'b1;
                  r_last  <= (K_LAST == '0);
               end
            end
            ST_STREAM: begin
               if (w_hs) begin
                  if (w_is_last) begin
                     r_state <= ST_IDLE;
                     r_k     <= '0;
                     r_s     <= '0;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_k     <= w_k_nxt;
                     r_s     <= w_s_nxt;
                     r_xi    <= w_x_i;
                     r_xq    <= w_x_q;
                     r_yi    <= w_y_i;
                     r_yq    <= w_y_q;
                     r_last  <= (w_k_nxt == K_LAST);
                  end
               end
            end
         endcase
      end
   end

   assign xi            = r_xi;
   assign xq            = r_xq;
   assign yi            = r_yi;
   assign yq            = r_yq;
   assign m_axis_tvalid = r_valid;
   assign sample_last   = r_last;
   assign shift         = r_s;
   assign busy          = (r_state == ST_STREAM);
   assign done          = r_done;

endmodule

// File: tb/tb_x_corr_src.sv
// Directed bench for x_corr_src: table of expected beats per sweep, checked
// under several ready patterns plus stall, abort and write-while-busy sequences.
module tb_x_corr_src;

   localparam int L = 5;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        wr_sel;
   logic [2:0]  wr_addr;
   logic [11:0] wr_i;
   logic [11:0] wr_q;
   logic        start;
   logic [11:0] xi, xq, yi, yq;
   logic        m_axis_tvalid;
   logic        s_axis_tready;
   logic        sample_last;
   logic [2:0]  shift;
   logic        busy;
   logic        done;

   x_corr_src dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_i(wr_i), .wr_q(wr_q), .start(start),
      .xi(xi), .xq(xq), .yi(yi), .yq(yq),
      .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
      .sample_last(sample_last), .shift(shift), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int k;
      int s;
      int xi;
      int xq;
      int yi;
      int yq;
      int last;
   } beat_t;

   beat_t tbl [L*L];
   int    xi_m [L];
   int    xq_m [L];
   int    yi_m [L];
   int    yq_m [L];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void build_tbl();
      for (int s = 0; s < L; s++)
         for (int k = 0; k < L; k++)
            tbl[s*L+k] = '{k, s, xi_m[k], xq_m[k], yi_m[(k+s)%L], yq_m[(k+s)%L], (k == L-1) ? 1 : 0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_buf(input logic sel, input int addr, input int di, input int dq);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_i = 12'(di); wr_q = 12'(dq);
      cyc();
      wr_en = 1'b0;
   endtask

   // mode 0: ready high; 1: ready toggles 1/0; 2: ready low 10 cycles at beat 17.
   // abort_at >= 0: pulse rst on that handshake. inject_at > 0: write y[0]=99 and pulse start then.
   task automatic run_sweep(input string tag, input int mode, input int abort_at, input int inject_at);
      int beat = 0, vcyc = 0, ndone = 0, done_iter = 0, stall_left = 10;
      bit aborting = 0, fin = 0, rdy;
      s_axis_tready = 1'b1;
      start = 1'b1;
      for (int it = 1; it <= 200 && !fin; it++) begin
         cyc();
         start = 1'b0;
         wr_en = 1'b0;
         if (aborting) begin
            rst = 1'b0;
            chk({tag, " abort_valid"}, int'(m_axis_tvalid), 0);
            chk({tag, " abort_busy"},  int'(busy), 0);
            chk({tag, " abort_done"},  int'(done), 0);
            chk({tag, " abort_shift"}, int'(shift), 0);
            chk({tag, " abort_xi"},    int'(xi), 0);
            fin = 1;
         end else begin
            if (done) begin
               ndone++;
               done_iter = it;
               fin = 1;
            end
            if (m_axis_tvalid) begin
               vcyc++;
               if (beat < L*L) begin
                  chk($sformatf("%s b%0d xi", tag, beat),    int'(xi),          tbl[beat].xi);
                  chk($sformatf("%s b%0d xq", tag, beat),    int'(xq),          tbl[beat].xq);
                  chk($sformatf("%s b%0d yi", tag, beat),    int'(yi),          tbl[beat].yi);
                  chk($sformatf("%s b%0d yq", tag, beat),    int'(yq),          tbl[beat].yq);
                  chk($sformatf("%s b%0d shift", tag, beat), int'(shift),       tbl[beat].s);
                  chk($sformatf("%s b%0d last", tag, beat),  int'(sample_last), tbl[beat].last);
                  chk($sformatf("%s b%0d busy", tag, beat),  int'(busy),        1);
               end else begin
                  chk({tag, " extra_beat"}, beat, L*L - 1);
               end
               rdy = 1'b1;
               if (mode == 1) rdy = (vcyc % 2) == 1;
               if (mode == 2 && beat == 17 && stall_left > 0) begin
                  rdy = 1'b0;
                  stall_left--;
               end
               s_axis_tready = rdy;
               if (rdy) begin
                  if (beat == abort_at) begin
                     rst = 1'b1;
                     aborting = 1;
                  end
                  beat++;
               end
            end
         end
         if (it == inject_at) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd0; wr_i = 12'd99; wr_q = 12'd99;
            start = 1'b1;
         end
      end
      if (abort_at < 0) begin
         chk({tag, " beats"},      beat, L*L);
         chk({tag, " done_count"}, ndone, 1);
         chk({tag, " valid_cycles"}, vcyc, (mode == 0) ? 25 : (mode == 1) ? 49 : 35);
         chk({tag, " done_cycle"}, done_iter, (mode == 0) ? 26 : (mode == 1) ? 50 : 36);
         chk({tag, " end_valid"},  int'(m_axis_tvalid), 0);
         chk({tag, " end_busy"},   int'(busy), 0);
         cyc();
         chk({tag, " done_pulse_width"}, int'(done), 0);
      end else if (!aborting) begin
         chk({tag, " abort_reached"}, 0, 1);
      end
      s_axis_tready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_i = '0; wr_q = '0;
      start = 1'b0; s_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst valid",  int'(m_axis_tvalid), 0);
      chk("rst busy",   int'(busy), 0);
      chk("rst done",   int'(done), 0);
      chk("rst shift",  int'(shift), 0);
      chk("rst last",   int'(sample_last), 0);
      chk("rst xi",     int'(xi), 0);
      chk("rst yi",     int'(yi), 0);
      rst = 1'b0;

      for (int k = 0; k < L; k++) begin
         xi_m[k] = k + 1;       xq_m[k] = 7 * (k + 1);
         yi_m[k] = 10 * (k + 1); yq_m[k] = 3 * (k + 1) + 1;
         write_buf(1'b0, k, xi_m[k], xq_m[k]);
         write_buf(1'b1, k, yi_m[k], yq_m[k]);
      end
      // out-of-range addresses must not disturb the buffers
      write_buf(1'b1, 7, 77, 77);
      write_buf(1'b0, 5, 88, 88);
      build_tbl();

      run_sweep("ready_high", 0, -1, -1);
      run_sweep("ready_toggle", 1, -1, -1);
      run_sweep("stall_inject", 2, -1, 5);
      run_sweep("after_inject", 0, -1, -1);

      run_sweep("abort12", 0, 12, -1);
      repeat (3) begin
         cyc();
         chk("post_abort done", int'(done), 0);
         chk("post_abort valid", int'(m_axis_tvalid), 0);
      end
      run_sweep("replay", 0, -1, -1);

      // write coinciding with start must be visible on the first sample
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_i = 12'd55; wr_q = 12'd66;
      xi_m[0] = 55; xq_m[0] = 66;
      build_tbl();
      run_sweep("start_write", 0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
